// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets, STATUS bit positions, serializer state
// encoding and the peripheral-window decode value used by Memory.
package uart_tx_mmio_pkg;

  // Register offsets (CPU address bit 0)
  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  // Address bits [15:14] that select this peripheral window
  localparam logic [1:0] PERIPH_BASE = 2'b01;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO used as the transmit byte queue.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data   write one entry at the rising edge
//   pop,  rd_data   rd_data shows the head combinationally; pop discards it
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
//
// Handshake: push/pop are single-cycle strobes. The caller only pushes when
// not full (or when popping in the same cycle) and only pops when not empty;
// the FIFO does not guard against misuse. Push and pop together leave count
// unchanged and advance both pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset: an empty FIFO never exposes it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // When full and popping/pushing together, the head is read here before
  // the write overwrites that same slot at the edge.
  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter (8N1) for the 0x4000-0x7FFF peripheral
// window. The CPU writes bytes to TXDATA; they queue in a FIFO and are
// serialized onto o_TX at CLKS_PER_BIT clocks per bit.
// Ports:
//   i_CLK       system clock
//   i_RESET_n   asynchronous active-low reset
//   i_Select    peripheral selected (decoded by Memory), gates writes
//   i_Address   register offset: 0 = TXDATA (write), 1 = STATUS (read)
//   i_Data      CPU write data
//   i_Write_EN  CPU write strobe
//   o_Data      read data, combinational, independent of i_Select
//   o_TX        serial line, registered, idle high
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_CLK,
  input  logic        i_RESET_n,
  input  logic        i_Select,
  input  logic        i_Address,
  input  logic [15:0] i_Data,
  input  logic        i_Write_EN,
  output logic [15:0] o_Data,
  output logic        o_TX
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rd_data;
  logic          wr_txdata;
  logic          wr_status;
  logic          push;
  logic          pop;
  logic          overflow;
  logic [15:0]   status;

  // Serializer state; kept as a named signal for debug visibility.
  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              tx_q;
  logic              baud_done;

  // Upper write-data byte carries no meaning for this block.
  logic unused_data_hi;
  assign unused_data_hi = ^i_Data[15:8];

  assign wr_txdata = i_Select & i_Write_EN & (i_Address == REG_TXDATA);
  assign wr_status = i_Select & i_Write_EN & (i_Address == REG_STATUS);

  // The serializer takes the head only from IDLE, so pop never happens on
  // an empty FIFO. A push into a full FIFO still fits if a pop frees a slot
  // in the same cycle.
  assign pop  = (state == ST_IDLE) & ~fifo_empty;
  assign push = wr_txdata & (~fifo_full | pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_CLK),
    .rst_n   (i_RESET_n),
    .push    (push),
    .pop     (pop),
    .wr_data (i_Data[7:0]),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky overflow: set by a dropped byte, cleared by writing STATUS with
  // bit 3 set. Set and clear target different offsets, so never coincide.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      overflow <= 1'b0;
    end else if (wr_txdata & ~push) begin
      overflow <= 1'b1;
    end else if (wr_status & i_Data[STAT_OVF]) begin
      overflow <= 1'b0;
    end
  end

  assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // tx_q is updated together with each state change so the line value is
  // registered and switches exactly on bit boundaries.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift    <= fifo_rd_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx_q     <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= ST_STOP;
            end else begin
              shift   <= shift >> 1;
              tx_q    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx_q     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_TX = tx_q;

  always_comb begin
    status                          = 16'h0000;
    status[STAT_BUSY]               = (state != ST_IDLE);
    status[STAT_FULL]               = fifo_full;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_OVF]                = overflow;
    status[STAT_COUNT_LSB +: 4]     = 4'(fifo_count);
  end

  // TXDATA is write-only and reads as zero; reads have no side effects.
  assign o_Data = (i_Address == REG_STATUS) ? status : 16'h0000;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The reference model keeps the FIFO as a byte queue and turns every
// dequeued byte into the list of line levels for its whole frame; a compare
// process checks o_TX and o_Data against it every cycle, and a line decoder
// checks each received byte against the expected queue.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        addr;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_CLK      (clk),
    .i_RESET_n  (rst_n),
    .i_Select   (sel),
    .i_Address  (addr),
    .i_Data     (wdata),
    .i_Write_EN (we),
    .o_Data     (rdata),
    .o_TX       (tx)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];      // bytes waiting in the FIFO
  logic [7:0] exp_q[$];    // bytes expected to appear on the line, in order
  logic       m_wave[$];   // line levels still to come for the current frame
  logic       m_busy = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_tx   = 1'b1;
  int         pre_size;
  bit         pop_now;
  logic [7:0] m_byte;
  logic       m_sym;

  // line decoder state
  bit         rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s = 16'h0000;
    s[0]   = m_busy;
    s[1]   = (m_q.size() == DEPTH);
    s[2]   = (m_q.size() == 0);
    s[3]   = m_ovf;
    s[7:4] = 4'(m_q.size());
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_wave.delete();
      m_busy    = 1'b0;
      m_ovf     = 1'b0;
      m_tx      = 1'b1;
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else begin
      pre_size = m_q.size();
      // A new frame may only begin after a full idle cycle on the line.
      pop_now  = !m_busy && (pre_size > 0);
      if (pop_now) begin
        m_byte = m_q.pop_front();
        exp_q.push_back(m_byte);
        for (int s = 0; s < 10; s++) begin
          m_sym = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : m_byte[s-1];
          for (int k = 0; k < CPB; k++) m_wave.push_back(m_sym);
        end
      end
      if (sel && we && addr == 1'b0) begin
        if (pre_size < DEPTH || pop_now) m_q.push_back(wdata[7:0]);
        else m_ovf = 1'b1;
      end
      if (sel && we && addr == 1'b1 && wdata[3]) m_ovf = 1'b0;
      if (m_wave.size() > 0) begin
        m_tx   = m_wave.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
    #1;
    check("tx_line", {15'b0, tx}, {15'b0, m_tx});
    check("read_data", rdata, addr ? model_status() : 16'h0000);
    // Decode the line: sample the middle of each bit, CPB cycles per bit.
    if (rst_n) begin
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        for (int k = 0; k < 8; k++)
          if (rx_cnt == CPB * (k + 1) + CPB / 2) rx_byte[k] = tx;
        if (rx_cnt == 9 * CPB + CPB / 2) begin
          check("rx_stop", {15'b0, tx}, 16'h0001);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL rx_byte: got %h expected none", rx_byte);
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_byte", {8'h00, rx_byte}, {8'h00, rx_exp});
          end
        end
        if (rx_cnt == 10 * CPB - 1) rx_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_reg(input logic a, input logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = 1'b1; wdata = 16'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!m_busy && m_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle: got busy expected idle within 3000 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] got_frame;
  logic [9:0] exp_frame;
  bit         found;
  int         r;

  initial begin
    rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 1'b1; wdata = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (20) @(negedge clk);
    #1;
    check("idle_status", rdata, 16'h0004);
    check("idle_tx", {15'b0, tx}, 16'h0001);

    // Single frame of 0x55; upper byte ignored
    write_reg(1'b0, 16'hAB55);
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 2 : CPB) @(posedge clk);
      #1 got_frame[i] = tx;
    end
    exp_frame = {1'b1, 8'h55, 1'b0};
    check("frame_55", {6'b0, got_frame}, {6'b0, exp_frame});
    wait_idle();
    #1 check("post_frame_status", rdata, 16'h0004);

    // Five back-to-back writes: first pops at once, FIFO ends full
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      sel = 1'b1; we = 1'b1; addr = 1'b0; wdata = {8'($urandom), 8'(i)};
      @(negedge clk);
    end
    sel = 1'b0; we = 1'b0; addr = 1'b1;
    #1 check("burst_full_status", rdata, 16'h0043);

    // Overflow while full and mid-frame, then clear it
    write_reg(1'b0, 16'h0077);
    #1 check("overflow_status", rdata, 16'h004B);
    write_reg(1'b1, 16'h0008);
    #1 check("overflow_clear", rdata, 16'h0043);

    // Push in the very cycle the serializer pops from the full FIFO
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL pop_slot: got no idle cycle expected one within 200 cycles");
    end
    check("pop_slot_full", {12'b0, 4'(m_q.size())}, 16'd4);
    sel = 1'b1; we = 1'b1; addr = 1'b0; wdata = 16'h0099;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = 1'b1;
    #1 check("push_on_pop_status", rdata, 16'h0043);
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r     = $urandom_range(0, 99);
      sel   = ($urandom_range(0, 9) != 0);
      we    = 1'b0;
      addr  = 1'($urandom_range(0, 1));
      wdata = 16'($urandom);
      if (r < 9) begin
        we = 1'b1; addr = 1'b0;
      end else if (r < 12) begin
        we = 1'b1; addr = 1'b1;
      end
    end
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = 1'b1;
    wait_idle();

    // Asynchronous reset in the middle of data bit 3 of 0xC3
    write_reg(1'b0, 16'h00C3);
    repeat (18) @(posedge clk);
    #1 check("tx_d3_before_reset", {15'b0, tx}, 16'h0000);
    #1 rst_n = 1'b0;
    #1 check("tx_async_reset", {15'b0, tx}, 16'h0001);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("status_after_reset", rdata, 16'h0004);
    repeat (100) @(negedge clk);
    #1 check("tx_quiet_after_reset", {15'b0, tx}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter peripheral; the first occupant of the 0x4000-0x7FFF peripheral window of the Hack memory map.
- Memory decodes i_Address[15:14]==2'b01 into i_Select and gates writes with it.
- Memory muxes this block's o_Data into the CPU read path.
- The CPU pushes bytes into an internal FIFO. An 8N1 serializer drains the FIFO onto o_TX at a fixed baud.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..8.

Ports:
- i_CLK  in  1  system clock
- i_RESET_n  in  1  asynchronous, active-low reset
- i_Select  in  1  peripheral selected (address decode from Memory)
- i_Address  in  1  register offset (CPU address bit 0)
- i_Data  in  16  CPU write data
- i_Write_EN  in  1  CPU write strobe
- o_Data  out  16  read data
- o_TX  out  1  UART serial line, idle high

Behaviour:
- Register map:
  - Offset 0 = TXDATA: write-only; reads return 16'h0000.
  - Offset 1 = STATUS: read; bit0 busy (serializer not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count, bits[15:8] 0.
- o_Data:
  - Combinational from i_Address and current state.
  - Independent of i_Select; Memory muxes it.
  - Reads have no side effects.
- Push:
  - Condition: i_Select & i_Write_EN & offset 0 at a rising edge.
  - Effect: i_Data[7:0] enters the FIFO; i_Data[15:8] ignored.
  - Accepted if count < FIFO_DEPTH, or if the serializer pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- Overflow clear: write to offset 1 with i_Data[3]=1. A clear and a set in the same cycle cannot collide (they use different offsets).
- Simultaneous push and pop: count unchanged; pointers both advance; write/read pointers wrap modulo FIFO_DEPTH.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE:
    - o_TX=1.
    - If FIFO not empty: pop the head into the 8-bit shift register, clear the baud counter and bit index, go to START.
  - START:
    - o_TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA:
    - o_TX = shift[0], LSB first.
    - Each bit lasts CLKS_PER_BIT cycles; shift right after each bit.
    - After bit index 7, go to STOP.
  - STOP:
    - o_TX=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - o_TX is registered, glitch-free.
  - Frame = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle between the stop bit and the next start bit.
- Latency: a push at edge N into an empty FIFO with the serializer idle:
  - Pop occurs at edge N+1.
  - o_TX falls at edge N+1.
  - busy reads 1 from edge N+1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
  - Terminal count advances the bit.
- Reset (asynchronous, any time including mid-frame):
  - o_TX=1 immediately.
  - State IDLE.
  - FIFO emptied (pointers and count 0).
  - overflow=0; shift register and counters 0.
  - Aborted frame is not resumed.

Decomposition:
- Shared package holds:
  - register offset constants: TXDATA=0, STATUS=1.
  - STATUS bit index constants.
  - FSM state encoding: 2-bit, IDLE=0, START=1, DATA=2, STOP=3.
  - peripheral base decode value 2'b01.
- One sub-module: sync_fifo (parameterized width 8, depth FIFO_DEPTH). Signals: push, pop, full, empty, count, async active-low reset.
- Serializer and register decode live in uart_tx_mmio.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset released, no writes -> o_TX=1 constantly; STATUS=16'h0004 (empty only).
- Write 16'hAB55 to offset 0 -> on o_TX, each bit held 4 cycles:
  - start 0.
  - data 1,0,1,0,1,0,1,0 (0x55 LSB first).
  - stop 1.
  - total 40 cycles.
  - busy=1 throughout the frame.
  - busy=0 after the frame; STATUS back to 16'h0004.
- Five consecutive single-cycle writes 0x01..0x05 from idle:
  - First byte pops at once, so the FIFO holds 4 and full=1 after the fifth write.
  - No overflow.
  - Five frames emitted with 1-cycle gaps.
- With the FIFO full and serializer mid-frame, write 0x77:
  - overflow=1 and count stays 4.
  - The byte never appears on o_TX.
  - Write 16'h0008 to offset 1 -> overflow=0.
- Write to offset 0 in the exact cycle the serializer pops from a full FIFO -> byte accepted, count stays 4, no overflow.
- Assert i_RESET_n=0 in the middle of DATA bit 3 -> o_TX=1 in the same cycle without a clock edge; after release STATUS=16'h0004 and no further frames.
